// File: rtl/ifmap_pkg.sv
// rtl/ifmap_pkg.sv - shared walker state type and default widths for the IFMap read side
package ifmap_pkg;

    localparam int PTR_W_DEF    = 8;
    localparam int STRIDE_W_DEF = 3;
    localparam int FILTER_W_DEF = 4;
    localparam int ROW_LEN_W_DEF = 5;
    localparam int ROWS_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        WALK     = 2'd2,
        STEP     = 2'd3
    } walker_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ifmap_window_fit.sv
// rtl/ifmap_window_fit.sv - combinational row-occupancy and window-fit comparator
module ifmap_window_fit
    import ifmap_pkg::*;
#(
    parameter int POINTER_SIZE  = PTR_W_DEF,
    parameter int STRIDE_SIZE   = STRIDE_W_DEF,
    parameter int FILTER_SIZE_W = FILTER_W_DEF,
    parameter int ROW_LEN_W     = ROW_LEN_W_DEF
) (
    input  logic [POINTER_SIZE-1:0]  write_pointer_i,
    input  logic [POINTER_SIZE-1:0]  row_start_i,
    input  logic [ROW_LEN_W-1:0]     win_base_i,
    input  logic [STRIDE_SIZE-1:0]   stride_i,
    input  logic [FILTER_SIZE_W-1:0] filter_size_i,
    input  logic [ROW_LEN_W-1:0]     row_len_i,
    output logic                     row_ready_o,
    output logic                     first_fits_o,
    output logic                     next_fits_o
);
    // One spare bit above the widest operand keeps base+stride+filter from overflowing.
    localparam int CMP_W = max3(ROW_LEN_W, FILTER_SIZE_W, STRIDE_SIZE) + 1;
    localparam int OCC_W = (POINTER_SIZE > ROW_LEN_W) ? POINTER_SIZE : ROW_LEN_W;

    logic [POINTER_SIZE-1:0] occ;

    // Occupancy wraps modulo the buffer depth; zero always means empty.
    assign occ          = write_pointer_i - row_start_i;
    assign row_ready_o  = OCC_W'(occ) >= OCC_W'(row_len_i);
    assign first_fits_o = CMP_W'(filter_size_i) <= CMP_W'(row_len_i);
    assign next_fits_o  = (CMP_W'(win_base_i) + CMP_W'(stride_i) + CMP_W'(filter_size_i))
                          <= CMP_W'(row_len_i);

endmodule

// File: rtl/ifmap_window_walker.sv
// rtl/ifmap_window_walker.sv - walks filter windows over buffered IFMap rows, one read pointer per tap
module ifmap_window_walker
    import ifmap_pkg::*;
#(
    parameter int POINTER_SIZE  = PTR_W_DEF,
    parameter int STRIDE_SIZE   = STRIDE_W_DEF,
    parameter int FILTER_SIZE_W = FILTER_W_DEF,
    parameter int ROW_LEN_W     = ROW_LEN_W_DEF,
    parameter int ROWS_W        = ROWS_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [STRIDE_SIZE-1:0]   cfg_stride,
    input  logic [FILTER_SIZE_W-1:0] cfg_filter_size,
    input  logic [ROW_LEN_W-1:0]     cfg_row_len,
    input  logic [ROWS_W-1:0]        cfg_num_rows,
    input  logic [POINTER_SIZE-1:0]  write_pointer,
    input  logic                     read_ready,
    output logic [POINTER_SIZE-1:0]  read_pointer,
    output logic                     read_valid,
    output logic                     co_filter,
    output logic                     end_row,
    output logic                     next_row,
    output logic                     busy,
    output logic                     done
);
    localparam logic [STRIDE_SIZE-1:0]   STRIDE_ONE = 1;
    localparam logic [FILTER_SIZE_W-1:0] FILT_ONE   = 1;
    localparam logic [ROWS_W-1:0]        ROWS_ONE   = 1;

    walker_state_t              state_q, state_d;
    logic [STRIDE_SIZE-1:0]     stride_q, stride_d;
    logic [FILTER_SIZE_W-1:0]   filter_q, filter_d;
    logic [ROW_LEN_W-1:0]       row_len_q, row_len_d;
    logic [ROWS_W-1:0]          num_rows_q, num_rows_d;
    logic [ROWS_W-1:0]          row_cnt_q, row_cnt_d, row_cnt_inc;
    logic [POINTER_SIZE-1:0]    row_start_q, row_start_d;
    logic [ROW_LEN_W-1:0]       win_base_q, win_base_d;
    logic [FILTER_SIZE_W-1:0]   tap_q, tap_d;
    logic [POINTER_SIZE-1:0]    read_pointer_q, read_pointer_d;
    logic                       read_valid_q, read_valid_d;
    logic                       co_filter_q, co_filter_d;
    logic                       end_row_q, end_row_d;
    logic                       next_row_q, next_row_d;
    logic                       done_q, done_d;
    logic                       row_ready, first_fits, next_fits;

    ifmap_window_fit #(
        .POINTER_SIZE  (POINTER_SIZE),
        .STRIDE_SIZE   (STRIDE_SIZE),
        .FILTER_SIZE_W (FILTER_SIZE_W),
        .ROW_LEN_W     (ROW_LEN_W)
    ) u_fit (
        .write_pointer_i (write_pointer),
        .row_start_i     (row_start_q),
        .win_base_i      (win_base_q),
        .stride_i        (stride_q),
        .filter_size_i   (filter_q),
        .row_len_i       (row_len_q),
        .row_ready_o     (row_ready),
        .first_fits_o    (first_fits),
        .next_fits_o     (next_fits)
    );

    assign row_cnt_inc  = row_cnt_q + ROWS_ONE;
    assign busy         = (state_q != IDLE);
    assign read_pointer = read_pointer_q;
    assign read_valid   = read_valid_q;
    assign co_filter    = co_filter_q;
    assign end_row      = end_row_q;
    assign next_row     = next_row_q;
    assign done         = done_q;

    // Next-state, counter and registered-output computation for the walker FSM.
    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        filter_d    = filter_q;
        row_len_d   = row_len_q;
        num_rows_d  = num_rows_q;
        row_cnt_d   = row_cnt_q;
        row_start_d = row_start_q;
        win_base_d  = win_base_q;
        tap_d       = tap_q;
        co_filter_d = 1'b0;
        end_row_d   = 1'b0;
        next_row_d  = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    stride_d   = (cfg_stride == '0) ? STRIDE_ONE : cfg_stride;
                    filter_d   = (cfg_filter_size == '0) ? FILT_ONE : cfg_filter_size;
                    row_len_d  = cfg_row_len;
                    num_rows_d = cfg_num_rows;
                    win_base_d = '0;
                    tap_d      = '0;
                    row_cnt_d  = '0;
                    if (cfg_num_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_ROW;
                    end
                end
            end
            WAIT_ROW: begin
                // A filter longer than the row yields no windows, so go straight to the row wrap-up.
                if (row_ready) begin
                    state_d = first_fits ? WALK : STEP;
                end
            end
            WALK: begin
                if (read_valid_q && read_ready) begin
                    if (tap_q == filter_q - FILT_ONE) begin
                        tap_d       = '0;
                        co_filter_d = 1'b1;
                        state_d     = STEP;
                    end else begin
                        tap_d = tap_q + FILT_ONE;
                    end
                end
            end
            STEP: begin
                if (next_fits) begin
                    win_base_d = win_base_q + ROW_LEN_W'(stride_q);
                    state_d    = WALK;
                end else begin
                    end_row_d   = 1'b1;
                    next_row_d  = 1'b1;
                    row_start_d = row_start_q + POINTER_SIZE'(row_len_q);
                    win_base_d  = '0;
                    row_cnt_d   = row_cnt_inc;
                    if (row_cnt_inc == num_rows_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_ROW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        read_valid_d   = (state_d == WALK);
        read_pointer_d = (state_d == WALK)
                         ? (row_start_d + POINTER_SIZE'(win_base_d) + POINTER_SIZE'(tap_d))
                         : read_pointer_q;
    end

    // State, configuration, counters and registered outputs; reset clears everything including row_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            stride_q       <= '0;
            filter_q       <= '0;
            row_len_q      <= '0;
            num_rows_q     <= '0;
            row_cnt_q      <= '0;
            row_start_q    <= '0;
            win_base_q     <= '0;
            tap_q          <= '0;
            read_pointer_q <= '0;
            read_valid_q   <= 1'b0;
            co_filter_q    <= 1'b0;
            end_row_q      <= 1'b0;
            next_row_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            stride_q       <= stride_d;
            filter_q       <= filter_d;
            row_len_q      <= row_len_d;
            num_rows_q     <= num_rows_d;
            row_cnt_q      <= row_cnt_d;
            row_start_q    <= row_start_d;
            win_base_q     <= win_base_d;
            tap_q          <= tap_d;
            read_pointer_q <= read_pointer_d;
            read_valid_q   <= read_valid_d;
            co_filter_q    <= co_filter_d;
            end_row_q      <= end_row_d;
            next_row_q     <= next_row_d;
            done_q         <= done_d;
        end
    end

endmodule

// File: tb/tb_ifmap_window_walker.sv
// tb/tb_ifmap_window_walker.sv - table-driven self-checking bench for ifmap_window_walker
module tb_ifmap_window_walker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] cfg_stride;
    logic [3:0] cfg_filter_size;
    logic [4:0] cfg_row_len;
    logic [7:0] cfg_num_rows;
    logic [7:0] write_pointer;
    logic       read_ready;
    logic [7:0] read_pointer;
    logic       read_valid;
    logic       co_filter;
    logic       end_row;
    logic       next_row;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int rs = 0;

    typedef struct {
        logic [2:0] stride;
        logic [3:0] filt;
        logic [4:0] rlen;
        logic [7:0] rows;
        logic [7:0] wp;
        logic [7:0] wp2;
        bit         toggle;
        int         exp_taps;
        int         exp_co;
        int         exp_ends;
        logic [7:0] exp_first;
    } job_t;

    job_t jobs[8];

    ifmap_window_walker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_stride      (cfg_stride),
        .cfg_filter_size (cfg_filter_size),
        .cfg_row_len     (cfg_row_len),
        .cfg_num_rows    (cfg_num_rows),
        .write_pointer   (write_pointer),
        .read_ready      (read_ready),
        .read_pointer    (read_pointer),
        .read_valid      (read_valid),
        .co_filter       (co_filter),
        .end_row         (end_row),
        .next_row        (next_row),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input job_t j, input int idx);
        int f, s, taps, co, ends, nr, cyc, stall, first_valid_cyc, done_cyc;
        logic [7:0] exp_q[$];
        logic [7:0] last_ptr, first_ptr;
        bit have_last, last_acc, seen_done;
        f = (j.filt == 0) ? 1 : int'(j.filt);
        s = (j.stride == 0) ? 1 : int'(j.stride);
        for (int r = 0; r < int'(j.rows); r++)
            for (int wb = 0; wb + f <= int'(j.rlen); wb += s)
                for (int t = 0; t < f; t++)
                    exp_q.push_back(8'(rs + r * int'(j.rlen) + wb + t));
        taps = 0; co = 0; ends = 0; nr = 0; stall = 0;
        first_valid_cyc = -1; done_cyc = -1;
        have_last = 0; last_acc = 0; seen_done = 0;
        last_ptr = '0; first_ptr = '0;
        write_pointer   = j.wp;
        cfg_stride      = j.stride;
        cfg_filter_size = j.filt;
        cfg_row_len     = j.rlen;
        cfg_num_rows    = j.rows;
        read_ready      = 1'b1;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_stride = 3'd5; cfg_filter_size = 4'd7; cfg_row_len = 5'd3; cfg_num_rows = 8'd9;
        cyc = 0;
        while (!seen_done && cyc < 2000) begin
            if (cyc == 0) check($sformatf("job%0d busy", idx), busy, (j.rows != 0));
            if (co_filter) co++;
            if (end_row) ends++;
            if (next_row) nr++;
            if (end_row || next_row)
                check($sformatf("job%0d end_row==next_row", idx), end_row, next_row);
            if (done) begin seen_done = 1; done_cyc = cyc; end
            if (j.wp2 != j.wp && ends >= 1 && stall < 10) begin
                check($sformatf("job%0d stall valid", idx), read_valid, 0);
                stall++;
                if (stall == 10) write_pointer = j.wp2;
            end
            read_ready = j.toggle ? ((cyc % 2) == 1) : 1'b1;
            if (read_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (have_last && !last_acc)
                    check($sformatf("job%0d ptr held", idx), read_pointer, last_ptr);
                if (read_ready) begin
                    if (taps == 0) first_ptr = read_pointer;
                    if (exp_q.size() > 0)
                        check($sformatf("job%0d tap%0d ptr", idx, taps), read_pointer, exp_q.pop_front());
                    else
                        check($sformatf("job%0d extra tap", idx), 1, 0);
                    taps++;
                end
                last_ptr = read_pointer; last_acc = read_ready; have_last = 1;
            end else begin
                have_last = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("job%0d done seen", idx), seen_done, 1);
        check($sformatf("job%0d taps", idx), taps, j.exp_taps);
        check($sformatf("job%0d co_filter", idx), co, j.exp_co);
        check($sformatf("job%0d end_row", idx), ends, j.exp_ends);
        check($sformatf("job%0d next_row", idx), nr, j.exp_ends);
        check($sformatf("job%0d model left", idx), exp_q.size(), 0);
        if (j.exp_taps > 0) begin
            check($sformatf("job%0d first ptr", idx), first_ptr, j.exp_first);
            check($sformatf("job%0d first valid cycle", idx), first_valid_cyc, 1);
        end
        if (j.rows == 0) check($sformatf("job%0d done latency", idx), done_cyc, 0);
        rs = (rs + int'(j.rows) * int'(j.rlen)) % 256;
    endtask

    initial begin
        job_t rj;
        //          stride filt  rlen  rows   wp      wp2     tog  taps co ends first
        jobs[0] = '{3'd1, 4'd3,  5'd8, 8'd1,  8'd8,   8'd8,   1'b0, 18, 6, 1,  8'd0};
        jobs[1] = '{3'd2, 4'd3,  5'd8, 8'd1,  8'd16,  8'd16,  1'b1, 9,  3, 1,  8'd8};
        jobs[2] = '{3'd3, 4'd3,  5'd8, 8'd2,  8'd24,  8'd32,  1'b0, 12, 4, 2,  8'd16};
        jobs[3] = '{3'd1, 4'd10, 5'd8, 8'd1,  8'd40,  8'd40,  1'b0, 0,  0, 1,  8'd0};
        jobs[4] = '{3'd0, 4'd2,  5'd4, 8'd1,  8'd44,  8'd44,  1'b0, 6,  3, 1,  8'd40};
        jobs[5] = '{3'd1, 4'd3,  5'd8, 8'd0,  8'd44,  8'd44,  1'b0, 0,  0, 0,  8'd0};
        jobs[6] = '{3'd1, 4'd10, 5'd8, 8'd26, 8'd252, 8'd252, 1'b0, 0,  0, 26, 8'd0};
        jobs[7] = '{3'd1, 4'd3,  5'd8, 8'd1,  8'd4,   8'd4,   1'b0, 18, 6, 1,  8'd252};

        rst_n = 1'b0; start = 1'b0; read_ready = 1'b1; write_pointer = '0;
        cfg_stride = '0; cfg_filter_size = '0; cfg_row_len = '0; cfg_num_rows = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset read_pointer", read_pointer, 0);
        check("reset read_valid", read_valid, 0);
        check("reset co_filter", co_filter, 0);
        check("reset end_row", end_row, 0);
        check("reset next_row", next_row, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_job(jobs[i], i);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of a walk: outputs drop without waiting for a clock edge.
        write_pointer = 8'd12; cfg_stride = 3'd1; cfg_filter_size = 4'd3;
        cfg_row_len = 5'd8; cfg_num_rows = 8'd1; read_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midwalk valid", read_valid, 1);
        check("midwalk busy", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst read_valid", read_valid, 0);
        check("async rst read_pointer", read_pointer, 0);
        check("async rst busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst idle", busy, 0);
        rs = 0;
        rj = '{3'd1, 4'd3, 5'd8, 8'd1, 8'd8, 8'd8, 1'b0, 18, 6, 1, 8'd0};
        run_job(rj, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
